// File: rtl/video_timing_gen_pkg.sv
// Shared types and colour constants for the video timing generator and its pattern source.
package video_timing_gen_pkg;

   typedef logic [11:0] coord_t;
   typedef logic [23:0] rgb_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   localparam logic [1:0] PAT_SOLID = 2'd0;
   localparam logic [1:0] PAT_BARS  = 2'd1;
   localparam logic [1:0] PAT_GRID  = 2'd2;
   localparam logic [1:0] PAT_RAMP  = 2'd3;

   localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
   localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
   localparam rgb_t RGB_CYAN    = 24'h00FFFF;
   localparam rgb_t RGB_GREEN   = 24'h00FF00;
   localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
   localparam rgb_t RGB_RED     = 24'hFF0000;
   localparam rgb_t RGB_BLUE    = 24'h0000FF;
   localparam rgb_t RGB_BLACK   = 24'h000000;

   function automatic rgb_t bar_color(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/video_pattern_rom.sv
// Combinational test-pattern source: maps the frame's pattern and pixel position to RGB.
module video_pattern_rom
   import video_timing_gen_pkg::*;
(
   input  logic [1:0] pattern,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [2:0] bar_idx,
   input  rgb_t       bg_color,
   output rgb_t       rgb
);

   always_comb begin
      rgb = RGB_BLACK;
      case (pattern)
         PAT_SOLID: rgb = bg_color;
         PAT_BARS:  rgb = bar_color(bar_idx);
         PAT_GRID:  rgb = (x[4:0] == 5'd0 || y[4:0] == 5'd0) ? RGB_WHITE : RGB_BLACK;
         PAT_RAMP:  rgb = {x, y, x ^ y};
         default:   rgb = RGB_BLACK;
      endcase
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, run/idle control and registered pixel outputs.
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] bg_color,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic [23:0] o_data,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_frame_start,
   output logic [31:0] o_frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t BAR_LAST = coord_t'(H_ACTIVE / 8 - 1);

   state_t     state, state_nx;
   coord_t     h_cnt, v_cnt, bar_w;
   logic [2:0] bar_idx;
   logic [1:0] pat_q;
   rgb_t       bg_q;

   logic       run, h_end, v_end, last_pix;
   logic       first_p0, de_p0, hs_p0, vs_p0;
   logic [1:0] pat_p0;
   rgb_t       bg_p0, rgb_p0;

   assign run      = (state == ST_RUN);
   assign h_end    = (h_cnt == H_LAST);
   assign v_end    = (v_cnt == V_LAST);
   assign last_pix = h_end && v_end;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // enable only matters while idle or on the final pixel, so frames are never cut short
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (enable) state_nx = ST_RUN;
         ST_RUN:  if (last_pix && !enable) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // bar_w/bar_idx track h_cnt so the bar colour needs no divider
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_w   <= '0;
         bar_idx <= '0;
      end else if (!run || last_pix) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_w   <= '0;
         bar_idx <= '0;
      end else if (h_end) begin
         h_cnt   <= '0;
         v_cnt   <= v_cnt + 12'd1;
         bar_w   <= '0;
         bar_idx <= '0;
      end else begin
         h_cnt <= h_cnt + 12'd1;
         if (bar_w == BAR_LAST) begin
            bar_w   <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_w <= bar_w + 12'd1;
         end
      end
   end

   // Stage p0: decode of the current counter position
   assign first_p0 = run && (h_cnt == '0) && (v_cnt == '0);
   assign de_p0    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_p0    = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_p0    = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign pat_p0   = first_p0 ? pattern_sel : pat_q;
   assign bg_p0    = first_p0 ? bg_color    : bg_q;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         pat_q <= PAT_SOLID;
         bg_q  <= RGB_BLACK;
      end else if (first_p0) begin
         pat_q <= pattern_sel;
         bg_q  <= bg_color;
      end
   end

   video_pattern_rom u_pattern_rom (
      .pattern  (pat_p0),
      .x        (h_cnt[7:0]),
      .y        (v_cnt[7:0]),
      .bar_idx  (bar_idx),
      .bg_color (bg_p0),
      .rgb      (rgb_p0)
   );

   // Stage p1: registered outputs, one pclk behind the counters
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         o_hs          <= ~HS_POL;
         o_vs          <= ~VS_POL;
         o_de          <= 1'b0;
         o_data        <= RGB_BLACK;
         o_x           <= '0;
         o_y           <= '0;
         o_frame_start <= 1'b0;
         o_frame_count <= '0;
      end else if (run) begin
         o_hs          <= hs_p0 ? HS_POL : ~HS_POL;
         o_vs          <= vs_p0 ? VS_POL : ~VS_POL;
         o_de          <= de_p0;
         o_data        <= de_p0 ? rgb_p0 : RGB_BLACK;
         o_x           <= h_cnt;
         o_y           <= v_cnt;
         o_frame_start <= first_p0;
         if (first_p0) o_frame_count <= o_frame_count + 32'd1;
      end else begin
         o_hs          <= ~HS_POL;
         o_vs          <= ~VS_POL;
         o_de          <= 1'b0;
         o_data        <= RGB_BLACK;
         o_x           <= '0;
         o_y           <= '0;
         o_frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 24x12 raster with a per-cycle reference scoreboard.
module tb_video_timing_gen;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] data;
      logic [11:0] x;
      logic [11:0] y;
      logic        fs;
      logic [31:0] fc;
   } obs_t;

   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic        pclk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [23:0] bg_color;
   logic        o_hs, o_vs, o_de, o_frame_start;
   logic [23:0] o_data;
   logic [11:0] o_x, o_y;
   logic [31:0] o_frame_count;

   video_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .pclk          (pclk),
      .rst           (rst),
      .enable        (enable),
      .pattern_sel   (pattern_sel),
      .bg_color      (bg_color),
      .o_hs          (o_hs),
      .o_vs          (o_vs),
      .o_de          (o_de),
      .o_data        (o_data),
      .o_x           (o_x),
      .o_y           (o_y),
      .o_frame_start (o_frame_start),
      .o_frame_count (o_frame_count)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;
   obs_t exp_q[$];

   // reference model state
   bit          m_run = 1'b0;
   int          mh = 0, mv = 0;
   logic [1:0]  m_pat = 2'd0;
   logic [23:0] m_bg = 24'h0;
   logic [31:0] m_fc = 32'd0;

   // observation statistics
   int cyc = 0;
   int de_ones, vs_ones, hs_ones, de_rise, hs_rise, last_fs, fs_seen, match, white, mode;
   bit gap_check = 1'b0;
   int fc_log[$];

   task automatic chk_int(input string tag, input int act, input int exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed hs=%b vs=%b de=%b d=%h x=%0d y=%0d fs=%b fc=%0d expected hs=%b vs=%b de=%b d=%h x=%0d y=%0d fs=%b fc=%0d",
                tag, act.hs, act.vs, act.de, act.data, act.x, act.y, act.fs, act.fc,
                exp.hs, exp.vs, exp.de, exp.data, exp.x, exp.y, exp.fs, exp.fc);
      end
   endtask

   function automatic logic [23:0] exp_color(input logic [1:0] p, input int x, input int y,
                                             input logic [23:0] bg);
      logic [7:0] xb, yb;
      xb = 8'(x);
      yb = 8'(y);
      case (p)
         2'd0:    return bg;
         2'd1:    return BARS[x / 2];
         2'd2:    return ((x % 32) == 0 || (y % 32) == 0) ? 24'hFFFFFF : 24'h000000;
         default: return {xb, yb, xb ^ yb};
      endcase
   endfunction

   // Predicts what the outputs show after the coming edge, given the inputs now applied.
   task automatic model_step(output obs_t e);
      bit de;
      e = '0;
      e.fc = m_fc;
      if (rst) begin
         m_run = 1'b0; mh = 0; mv = 0; m_fc = 32'd0;
         e.fc = 32'd0;
      end else if (m_run) begin
         if (mh == 0 && mv == 0) begin
            m_pat = pattern_sel;
            m_bg  = bg_color;
            m_fc  = m_fc + 32'd1;
         end
         de     = (mh < 16) && (mv < 8);
         e.hs   = (mh >= 18) && (mh < 21);
         e.vs   = (mv >= 9) && (mv < 11);
         e.de   = de;
         e.data = de ? exp_color(m_pat, mh, mv, m_bg) : 24'h0;
         e.x    = 12'(mh);
         e.y    = 12'(mv);
         e.fs   = (mh == 0) && (mv == 0);
         e.fc   = m_fc;
         if (mh == 23 && mv == 11 && !enable) begin
            m_run = 1'b0; mh = 0; mv = 0;
         end else if (mh == 23) begin
            mh = 0;
            mv = (mv == 11) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end else if (enable) begin
         m_run = 1'b1;
      end
   endtask

   task automatic tick();
      obs_t e, a;
      @(negedge pclk);
      model_step(e);
      exp_q.push_back(e);
      @(posedge pclk);
      #1;
      cyc++;
      a = '{o_hs, o_vs, o_de, o_data, o_x, o_y, o_frame_start, o_frame_count};
      e = exp_q.pop_front();
      chk_obs("pix", a, e);
      if (o_de) de_ones++;
      if (o_vs) vs_ones++;
      if (o_hs) hs_ones++;
      if (o_de && de_rise < 0) de_rise = cyc;
      if (o_hs && hs_rise < 0) hs_rise = cyc;
      if (o_frame_start) begin
         fs_seen++;
         fc_log.push_back(int'(o_frame_count));
         if (gap_check && last_fs >= 0) chk_int("fs_gap", cyc - last_fs, 288);
         last_fs = cyc;
      end
      if (o_de && mode == 1 && o_data === BARS[o_x >> 1]) match++;
      if (o_de && mode == 2 && o_data === 24'h123456) match++;
      if (o_de && mode == 3) begin
         if (o_data === ((o_x == 12'd0 || o_y == 12'd0) ? 24'hFFFFFF : 24'h000000)) match++;
         if (o_data === 24'hFFFFFF) white++;
      end
   endtask

   task automatic clear_stats();
      de_ones = 0; vs_ones = 0; hs_ones = 0; de_rise = -1; hs_rise = -1;
      last_fs = -1; fs_seen = 0; match = 0; white = 0;
      fc_log.delete();
   endtask

   initial begin
      int en_cyc;
      rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; bg_color = 24'h123456;
      mode = 0;
      clear_stats();
      tick();
      tick();
      chk_obs("reset_state", '{o_hs, o_vs, o_de, o_data, o_x, o_y, o_frame_start, o_frame_count}, '0);

      rst = 1'b0;
      tick();
      tick();

      // start running: solid background, timing and frame bookkeeping
      enable = 1'b1;
      clear_stats();
      tick();
      en_cyc = cyc;
      gap_check = 1'b1;
      mode = 2;
      repeat (288) tick();
      chk_int("de_latency", de_rise - en_cyc, 1);
      chk_int("hs_offset", hs_rise - de_rise, 18);
      chk_int("de_count", de_ones, 128);
      chk_int("vs_count", vs_ones, 48);
      chk_int("hs_count", hs_ones, 36);
      chk_int("solid_pix", match, 128);
      repeat (576) tick();
      chk_int("fs_pulses", fc_log.size(), 3);
      for (int i = 0; i < fc_log.size(); i++) chk_int("fc_value", fc_log[i], i + 1);
      gap_check = 1'b0;

      // colour bars
      pattern_sel = 2'd1;
      mode = 1; match = 0;
      repeat (288) tick();
      chk_int("bars_pix", match, 128);

      // switching to grid mid-frame must not affect the current frame
      pattern_sel = 2'd0;
      mode = 2; match = 0;
      repeat (100) tick();
      pattern_sel = 2'd2;
      repeat (188) tick();
      chk_int("solid_hold", match, 128);
      mode = 3; match = 0; white = 0;
      repeat (288) tick();
      chk_int("grid_pix", match, 128);
      chk_int("grid_white", white, 23);

      // ramp frame, with enable dropped at v = 4
      pattern_sel = 2'd3;
      mode = 0;
      repeat (96) tick();
      enable = 1'b0;
      clear_stats();
      repeat (192) tick();
      chk_int("drop_last_x", int'(o_x), 23);
      chk_int("drop_last_y", int'(o_y), 11);
      clear_stats();
      repeat (100) tick();
      chk_int("idle_no_fs", fs_seen, 0);
      chk_int("idle_no_de", de_ones, 0);
      chk_int("idle_fc_hold", int'(o_frame_count), 7);

      // reset in the middle of a frame at h = 7, v = 3
      enable = 1'b1;
      tick();
      repeat (79) tick();
      chk_int("fc_pre_rst", int'(o_frame_count), 8);
      rst = 1'b1;
      #1;
      chk_int("rst_async_fc", int'(o_frame_count), 0);
      chk_int("rst_async_de", int'(o_de), 0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk_int("restart_fs", int'(o_frame_start), 1);
      chk_int("restart_fc", int'(o_frame_count), 1);
      chk_int("restart_x", int'(o_x), 0);
      repeat (30) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
